parking_gate_ctrl: RTL and testbench
====================================

Name: parking_gate_ctrl

Overview:
Sequences the entrance and exit gates of the 3-spot parking lot. The two gates share one single-lane ramp, so only one gate may be open at a time. The block arbitrates between a car waiting to enter and a car waiting to leave, using `spot_left` from the spot counter. It times out stalled gate openings and keeps a saturating tally of completed entries for the HEX display path.

Parameters:
- `GATE_HOLD`, 8: maximum cycles a gate stays open while waiting for the car to pass; must be >= 2.
- `ENTRY_W`, 8: width of the completed-entry tally.

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `spot_left`  in  2  free spots (0..3), from the spot counter
- `arrive`  in  1  car present at entrance sensor (level)
- `exit_req`  in  1  car present at exit sensor (level)
- `enter_pass`  in  1  car cleared entrance gate (1-cycle pulse)
- `exit_pass`  in  1  car cleared exit gate (1-cycle pulse)
- `gate_in`  out  1  entrance gate open
- `gate_out`  out  1  exit gate open
- `full`  out  1  lot full indicator
- `timeout`  out  1  1-cycle pulse when a gate closes without a pass
- `entries`  out  ENTRY_W  completed entries, saturating

Behaviour:
- Clock and reset: single clock `clk`. Reset is synchronous and active-high on `reset`. All inputs are already synchronized to `clk` upstream.
- Reset values: state=IDLE, `gate_in`=0, `gate_out`=0, `full`=0, `timeout`=0, `entries`=0, hold counter=0, `last_grant`=OUT (so the first tie goes to entry).
- Reset mid-operation: reset takes priority over every transition. A gate that is open closes at the same edge.
- States: IDLE, IN_OPEN, OUT_OPEN, SETTLE. All outputs are registered and derived from the state: `gate_in`=1 only in IN_OPEN, `gate_out`=1 only in OUT_OPEN.
- IDLE grant rules, evaluated every cycle:
  - `arrive` & !`exit_req` & `spot_left`!=0 -> IN_OPEN.
  - `exit_req` & !`arrive` -> OUT_OPEN.
  - `arrive` & `exit_req` & `spot_left`==0 -> OUT_OPEN.
  - `arrive` & `exit_req` & `spot_left`!=0 -> grant the side opposite `last_grant`.
  - `arrive` & `spot_left`==0 & !`exit_req` -> stay in IDLE.
- `last_grant` updates on every grant.
- Latency: a request seen at edge N gives an open gate after edge N, i.e. visible in cycle N+1.
- IN_OPEN / OUT_OPEN:
  - The hold counter clears on entry and increments every cycle.
  - Matching pass pulse -> SETTLE.
  - Counter == `GATE_HOLD`-1 with no pass -> SETTLE, and `timeout`=1 for exactly the next cycle.
  - Pass and limit in the same cycle: the pass wins, with no timeout.
  - Pass pulses for the closed gate are ignored.
  - `spot_left` dropping to 0 while IN_OPEN does not abort the opening.
- SETTLE: exactly 1 cycle with both gates closed, then IDLE. This guarantees a dead cycle between any two openings, including back-to-back grants to the same side.
- `entries`: increments by 1 on an `enter_pass` accepted in IN_OPEN. It saturates at 2^`ENTRY_W`-1 and never wraps. Exits do not decrement it.
- `full`: registered `spot_left`==0 (1-cycle latency), independent of state.
- Hold counter width: $clog2(`GATE_HOLD`). The counter never exceeds `GATE_HOLD`-1.
- Outside IDLE, `arrive` / `exit_req` are held requests. They are re-evaluated only on return to IDLE; there is no queueing.

Decomposition:
- Shared package `parking_pkg`:
  - enum `gate_state_t` {IDLE, IN_OPEN, OUT_OPEN, SETTLE}.
  - enum `side_t` {SIDE_IN, SIDE_OUT}.
  - constant `NUM_SPOTS`=3.
- Sub-module `hold_timer`: a parameterized clear/increment counter with a limit flag. It is used once, for the gate hold counter.
- Arbitration and the FSM stay in the top module.

Test Plan:
1. Reset, then `arrive`=1, `spot_left`=3, `enter_pass` at the 3rd open cycle -> `gate_in`=1 for 3 cycles, then SETTLE, then `entries`=1, `timeout`=0.
2. `arrive`=1, `spot_left`=0, `exit_req`=0 for 10 cycles -> `gate_in` stays 0 and `full`=1 from the 2nd cycle.
3. `arrive`=`exit_req`=1 held, `spot_left`=2, passes given promptly -> grants alternate IN, OUT, IN, OUT, with one SETTLE cycle between each and never both gates high.
4. `exit_req`=1 with no `exit_pass`, `GATE_HOLD`=8 -> `gate_out`=1 for exactly 8 cycles, `timeout` pulses once, then IDLE.
5. `ENTRY_W`=2 with 5 accepted entries -> `entries` reads 1, 2, 3, 3, 3.
6. Assert `reset` during IN_OPEN with `entries`=2 -> next cycle `gate_in`=0, `entries`=0, state IDLE; a stray `enter_pass` in IDLE leaves `entries` at 0.

Source files
------------

// File: rtl/parking_gate_ctrl_pkg.sv
// Shared types for the parking lot gate controller.
package parking_pkg;

   localparam int NUM_SPOTS = 3;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      IN_OPEN  = 2'd1,
      OUT_OPEN = 2'd2,
      SETTLE   = 2'd3
   } gate_state_t;

   typedef enum logic {
      SIDE_IN  = 1'b0,
      SIDE_OUT = 1'b1
   } side_t;

endpackage

// File: rtl/parking_gate_ctrl_hold_timer.sv
// Clear/increment counter that stops at LIMIT-1 and flags when it gets there.
module hold_timer #(
   parameter int LIMIT = 8,
   parameter int CW    = (LIMIT > 1) ? $clog2(LIMIT) : 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clr,
   input  logic          inc,
   output logic [CW-1:0] cnt,
   output logic          at_limit
);

   assign at_limit = (cnt == CW'(LIMIT - 1));

   always_ff @(posedge clk) begin
      if (reset || clr)
         cnt <= '0;
      else if (inc && !at_limit)
         cnt <= cnt + CW'(1);
   end

endmodule

// File: rtl/parking_gate_ctrl.sv
// Single-ramp entrance/exit gate sequencer with hold timeout and entry tally.
module parking_gate_ctrl
   import parking_pkg::*;
#(
   parameter int GATE_HOLD = 8,
   parameter int ENTRY_W   = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [1:0]         spot_left,
   input  logic               arrive,
   input  logic               exit_req,
   input  logic               enter_pass,
   input  logic               exit_pass,
   output logic               gate_in,
   output logic               gate_out,
   output logic               full,
   output logic               timeout,
   output logic [ENTRY_W-1:0] entries
);

   localparam int HW = (GATE_HOLD > 1) ? $clog2(GATE_HOLD) : 1;

   gate_state_t   state, nxt;
   side_t         last_grant;
   logic [HW-1:0] hold_cnt;
   logic          at_limit;
   logic          gate_open;
   logic          side_pass;
   logic          lot_empty_slot;

   assign gate_open      = (state == IN_OPEN) || (state == OUT_OPEN);
   assign side_pass      = ((state == IN_OPEN) && enter_pass) ||
                           ((state == OUT_OPEN) && exit_pass);
   assign lot_empty_slot = (spot_left != 2'd0);

   // Held at zero whenever no gate is open, so every opening starts from 0.
   hold_timer #(.LIMIT(GATE_HOLD), .CW(HW)) u_hold (
      .clk      (clk),
      .reset    (reset),
      .clr      (!gate_open),
      .inc      (gate_open),
      .cnt      (hold_cnt),
      .at_limit (at_limit)
   );

   always_comb begin
      nxt = state;
      case (state)
         IDLE: begin
            if (arrive && exit_req) begin
               // A full lot always lets the leaver out; otherwise alternate.
               if (!lot_empty_slot || (last_grant == SIDE_IN))
                  nxt = OUT_OPEN;
               else
                  nxt = IN_OPEN;
            end else if (arrive && lot_empty_slot)
               nxt = IN_OPEN;
            else if (exit_req)
               nxt = OUT_OPEN;
         end
         IN_OPEN, OUT_OPEN: begin
            if (side_pass || at_limit)
               nxt = SETTLE;
         end
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         last_grant <= SIDE_OUT;
         gate_in    <= 1'b0;
         gate_out   <= 1'b0;
         full       <= 1'b0;
         timeout    <= 1'b0;
         entries    <= '0;
      end else begin
         state    <= nxt;
         gate_in  <= (nxt == IN_OPEN);
         gate_out <= (nxt == OUT_OPEN);
         full     <= !lot_empty_slot;
         timeout  <= gate_open && at_limit && !side_pass;
         if (state == IDLE && nxt == IN_OPEN)
            last_grant <= SIDE_IN;
         else if (state == IDLE && nxt == OUT_OPEN)
            last_grant <= SIDE_OUT;
         if ((state == IN_OPEN) && enter_pass && (entries != {ENTRY_W{1'b1}}))
            entries <= entries + ENTRY_W'(1);
      end
   end

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed bench for parking_gate_ctrl; a second instance with ENTRY_W=2 checks saturation.
module tb_parking_gate_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] spot_left;
   logic       arrive, exit_req, enter_pass, exit_pass;
   logic       gate_in, gate_out, full, timeout;
   logic [7:0] entries;
   logic       gate_in2, gate_out2, full2, timeout2;
   logic [1:0] entries2;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   parking_gate_ctrl #(.GATE_HOLD(8), .ENTRY_W(8)) dut (
      .clk(clk), .reset(reset), .spot_left(spot_left), .arrive(arrive),
      .exit_req(exit_req), .enter_pass(enter_pass), .exit_pass(exit_pass),
      .gate_in(gate_in), .gate_out(gate_out), .full(full), .timeout(timeout),
      .entries(entries)
   );

   parking_gate_ctrl #(.GATE_HOLD(8), .ENTRY_W(2)) dut_w2 (
      .clk(clk), .reset(reset), .spot_left(spot_left), .arrive(arrive),
      .exit_req(exit_req), .enter_pass(enter_pass), .exit_pass(exit_pass),
      .gate_in(gate_in2), .gate_out(gate_out2), .full(full2), .timeout(timeout2),
      .entries(entries2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; spot_left = 2'd3; arrive = 1'b0; exit_req = 1'b0;
      enter_pass = 1'b0; exit_pass = 1'b0;
      tick(); tick();
      reset = 1'b0;
      chk("rst_gate_in", gate_in, 0);
      chk("rst_gate_out", gate_out, 0);
      chk("rst_full", full, 0);
      chk("rst_timeout", timeout, 0);
      chk("rst_entries", entries, 0);

      // Single entry, pass in the 3rd open cycle
      arrive = 1'b1;
      tick();
      arrive = 1'b0;
      chk("t1_open1", gate_in, 1);
      tick();
      chk("t1_open2", gate_in, 1);
      tick();
      chk("t1_open3", gate_in, 1);
      chk("t1_out_closed", gate_out, 0);
      enter_pass = 1'b1;
      tick();
      enter_pass = 1'b0;
      chk("t1_settle_in", gate_in, 0);
      chk("t1_entries", entries, 1);
      chk("t1_entries_w2", entries2, 1);
      chk("t1_timeout", timeout, 0);
      tick();
      chk("t1_idle_in", gate_in, 0);

      // Lot full: arrival is refused, full follows spot_left one cycle later
      arrive = 1'b1; spot_left = 2'd0;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("t2_gate_in", gate_in, 0);
         chk("t2_full", full, 1);
      end
      arrive = 1'b0; spot_left = 2'd2;
      tick();
      chk("t2_full_clear", full, 0);

      // Exit with no pass: 8 open cycles then a timeout pulse; stray enter_pass ignored
      exit_req = 1'b1;
      tick();
      exit_req = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         chk("t4_gate_out", gate_out, 1);
         chk("t4_no_timeout", timeout, 0);
         enter_pass = (k == 3);
         tick();
      end
      enter_pass = 1'b0;
      chk("t4_closed", gate_out, 0);
      chk("t4_timeout", timeout, 1);
      chk("t4_entries", entries, 1);
      tick();
      chk("t4_timeout_once", timeout, 0);
      chk("t4_idle", gate_out, 0);

      // Both sides waiting with room: grants alternate IN, OUT, IN, OUT
      arrive = 1'b1; exit_req = 1'b1; spot_left = 2'd2;
      for (int g = 0; g < 4; g++) begin
         tick();
         chk("t3_gate_in", gate_in, (g % 2 == 0));
         chk("t3_gate_out", gate_out, (g % 2 == 1));
         enter_pass = (g % 2 == 0);
         exit_pass  = (g % 2 == 1);
         tick();
         enter_pass = 1'b0; exit_pass = 1'b0;
         if (g == 3) begin arrive = 1'b0; exit_req = 1'b0; end
         chk("t3_settle_both", {gate_in, gate_out}, 0);
         chk("t3_settle_to", timeout, 0);
         tick();
         chk("t3_idle_both", {gate_in, gate_out}, 0);
      end
      chk("t3_entries", entries, 3);
      chk("t3_entries_w2", entries2, 3);

      // Two more entries; the second passes on the limit cycle (pass wins)
      spot_left = 2'd3;
      arrive = 1'b1;
      tick();
      arrive = 1'b0;
      enter_pass = 1'b1;
      tick();
      enter_pass = 1'b0;
      chk("t5_entries4", entries, 4);
      chk("t5_sat_w2_a", entries2, 3);
      tick();
      arrive = 1'b1;
      tick();
      arrive = 1'b0;
      for (int k = 1; k < 8; k++) tick();
      chk("t5_still_open", gate_in, 1);
      enter_pass = 1'b1;
      tick();
      enter_pass = 1'b0;
      chk("t5_limit_closed", gate_in, 0);
      chk("t5_limit_no_to", timeout, 0);
      chk("t5_entries5", entries, 5);
      chk("t5_sat_w2_b", entries2, 3);
      tick();

      // Reset while the entrance gate is open
      arrive = 1'b1;
      tick();
      arrive = 1'b0;
      chk("t6_open", gate_in, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("t6_gate_in", gate_in, 0);
      chk("t6_entries", entries, 0);
      chk("t6_entries_w2", entries2, 0);
      enter_pass = 1'b1;
      tick();
      enter_pass = 1'b0;
      chk("t6_stray_pass", entries, 0);
      chk("t6_idle", {gate_in, gate_out}, 0);

      // After reset the first tie goes to entry; a full lot favours exit
      arrive = 1'b1; exit_req = 1'b1; spot_left = 2'd1;
      tick();
      arrive = 1'b0; exit_req = 1'b0;
      chk("t7_tie_in", {gate_in, gate_out}, 2'b10);
      enter_pass = 1'b1;
      tick();
      enter_pass = 1'b0;
      tick();
      arrive = 1'b1; exit_req = 1'b1; spot_left = 2'd0;
      tick();
      arrive = 1'b0; exit_req = 1'b0;
      chk("t7_full_out", {gate_in, gate_out}, 2'b01);
      exit_pass = 1'b1;
      tick();
      exit_pass = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
